// File: rtl/mac_feeder_pkg.sv
// Shared widths, FSM encoding and index-width helper for the MAC feeder.
package mac_feeder_pkg;

    localparam int PIX_W  = 8;
    localparam int W_W    = 8;
    localparam int ACC_W  = 20;
    localparam int PROD_W = PIX_W + W_W;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    function automatic int idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/mac_feeder_wbank.sv
// Kernel weight register file: one write port, one tap-indexed async read port.
module mac_feeder_wbank
    import mac_feeder_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W_W-1:0]   wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W_W-1:0]   rd_data
);

    // Power-of-two depth keeps every index value in range; unused rows stay zero.
    localparam int DEPTH = 1 << IDX_W;

    logic [W_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mac_feeder.sv
// Feeds pixel*weight products to an external accumulator and returns one sum per window.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | accepting TAPS kernel weights, pixels blocked
// ST_RUN    | accepting window pixels, one product issued per pixel
// ST_WAIT   | two cycles: last product issue, accumulator settle
// ST_RESULT | window sum presented until res_ready
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int TAPS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [W_W-1:0]   cfg_weight,
    output logic             cfg_ready,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             acc_en,
    output logic             acc_load,
    output logic [ACC_W-1:0] acc_data,
    input  logic [ACC_W-1:0] acc_result,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    input  logic             res_ready
);

    localparam int IDX_W = idx_width(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t state, state_nxt;

    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  t;
    logic              wait_cnt;
    logic [W_W-1:0]    w_rd;
    logic [PROD_W-1:0] prod;

    logic cfg_fire, pix_fire, res_fire;
    logic cfg_last, pix_last, wait_done;

    assign cfg_fire  = cfg_valid & cfg_ready;
    assign pix_fire  = pix_valid & pix_ready;
    assign res_fire  = res_ready & res_valid;
    assign cfg_last  = cfg_fire && (k == LAST_IDX);
    assign pix_last  = pix_fire && (t == LAST_IDX);
    assign wait_done = (state == ST_WAIT) && (wait_cnt == 1'b0);

    mac_feeder_wbank #(
        .IDX_W (IDX_W)
    ) u_wbank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cfg_fire),
        .wr_idx  (k),
        .wr_data (cfg_weight),
        .rd_idx  (t),
        .rd_data (w_rd)
    );

    assign prod = PROD_W'(pix_data) * PROD_W'(w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:   if (cfg_last)  state_nxt = ST_RUN;
            ST_RUN:    if (pix_last)  state_nxt = ST_WAIT;
            ST_WAIT:   if (wait_done) state_nxt = ST_RESULT;
            ST_RESULT: if (res_fire)  state_nxt = ST_RUN;
            default:                  state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        pix_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_LOAD:   cfg_ready = 1'b1;
            ST_RUN:    pix_ready = 1'b1;
            ST_RESULT: res_valid = 1'b1;
            default:   ;
        endcase
    end

    // Product path is registered so the accumulator sees one product per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            t        <= '0;
            wait_cnt <= 1'b0;
            acc_en   <= 1'b0;
            acc_load <= 1'b0;
            acc_data <= '0;
            res_data <= '0;
        end else begin
            acc_en   <= pix_fire;
            acc_load <= pix_fire && (t == '0);
            acc_data <= pix_fire ? ACC_W'(prod) : '0;

            if (cfg_fire) begin
                k <= cfg_last ? '0 : k + IDX_W'(1);
            end

            if (pix_fire) begin
                t <= pix_last ? '0 : t + IDX_W'(1);
            end

            // Down-counter spans the two WAIT cycles; terminal count captures the sum.
            if (pix_last) begin
                wait_cnt <= 1'b1;
            end else if ((state == ST_WAIT) && (wait_cnt != 1'b0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (wait_done) begin
                res_data <= acc_result;
            end
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural accumulator on the acc_* port.
module tb_mac_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [7:0]  cfg_weight;
    logic        cfg_ready;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        acc_en;
    logic        acc_load;
    logic [19:0] acc_data;
    logic [19:0] acc_result;
    logic        res_valid;
    logic [19:0] res_data;
    logic        res_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] wv [9];
    logic [7:0] pv [9];

    always #5 clk = ~clk;

    mac_feeder #(.TAPS(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_weight (cfg_weight),
        .cfg_ready  (cfg_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .acc_en     (acc_en),
        .acc_load   (acc_load),
        .acc_data   (acc_data),
        .acc_result (acc_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready)
    );

    logic [19:0] acc_q;
    always @(posedge clk) begin
        if (rst) acc_q <= '0;
        else if (acc_en) acc_q <= acc_load ? acc_data : acc_q + acc_data;
    end
    assign acc_result = acc_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; cfg_valid = 1'b0; cfg_weight = '0;
        pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic load_weights();
        for (int i = 0; i < 9; i++) begin
            cfg_valid = 1'b1; cfg_weight = wv[i];
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int gap);
        logic [19:0] exp_d;
        logic        exp_l;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    checks++;
                    if (acc_en !== 1'b0 || acc_data !== 20'd0) begin
                        errors++;
                        $display("FAIL gap_idle: acc_en=%b acc_data=%0d, want 0/0", acc_en, acc_data);
                    end
                end
            end
            checks++;
            if (pix_ready !== 1'b1) begin
                errors++;
                $display("FAIL pix_ready_run tap %0d: got %b want 1", i, pix_ready);
            end
            pix_valid = 1'b1; pix_data = pv[i];
            step();
            pix_valid = 1'b0;
            exp_d = 20'(pv[i]) * 20'(wv[i]);
            exp_l = (i == 0);
            checks++;
            if (acc_en !== 1'b1 || acc_load !== exp_l || acc_data !== exp_d) begin
                errors++;
                $display("FAIL tap_issue %0d: en=%b load=%b data=%0d, want 1/%b/%0d",
                         i, acc_en, acc_load, acc_data, exp_l, exp_d);
            end
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic check_window(input string name, input logic [19:0] exp_sum);
        int n;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait_pix_ready: got %b want 0", name, pix_ready);
        end
        wait_result(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s_latency: res_valid after %0d cycles past last-tap edge, want 2", name, n);
        end
        checks++;
        if (res_data !== exp_sum) begin
            errors++;
            $display("FAIL %s_sum: got %0d want %0d", name, res_data, exp_sum);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (cfg_ready !== 1'b1 || pix_ready !== 1'b0 || acc_en !== 1'b0 || acc_load !== 1'b0 ||
            acc_data !== 20'd0 || res_valid !== 1'b0 || res_data !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: cfg_rdy=%b pix_rdy=%b en=%b load=%b data=%0d rv=%b rd=%0d",
                     cfg_ready, pix_ready, acc_en, acc_load, acc_data, res_valid, res_data);
        end
    endtask

    task automatic test_basic();
        reset_dut();
        for (int i = 0; i < 9; i++) begin wv[i] = 8'(i + 1); pv[i] = 8'd10; end
        load_weights();
        checks++;
        if (cfg_ready !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_run_entry: cfg_ready=%b pix_ready=%b want 0/1", cfg_ready, pix_ready);
        end
        send_pixels(9, 0);
        check_window("basic", 20'd450);
        accept_result();
        checks++;
        if (res_valid !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: res_valid=%b pix_ready=%b want 0/1", res_valid, pix_ready);
        end
    endtask

    task automatic test_gaps();
        send_pixels(9, 2);
        check_window("gaps", 20'd450);
        accept_result();
    endtask

    task automatic test_result_hold();
        reset_dut();
        for (int i = 0; i < 9; i++) begin wv[i] = 8'(i + 1); pv[i] = 8'd10; end
        load_weights();
        send_pixels(9, 0);
        check_window("hold", 20'd450);
        for (int c = 0; c < 5; c++) begin
            pix_valid = 1'b1; pix_data = 8'd99;
            step();
            checks++;
            if (res_valid !== 1'b1 || res_data !== 20'd450 || pix_ready !== 1'b0 || acc_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle %0d: rv=%b rd=%0d pix_rdy=%b en=%b want 1/450/0/0",
                         c, res_valid, res_data, pix_ready, acc_en);
            end
        end
        pix_valid = 1'b0;
        accept_result();
        for (int i = 0; i < 9; i++) pv[i] = 8'(i + 1);
        send_pixels(9, 0);
        check_window("hold_next", 20'd285);
        accept_result();
    endtask

    task automatic test_ignore();
        res_ready = 1'b1; cfg_valid = 1'b1; cfg_weight = 8'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (res_valid !== 1'b0 || cfg_ready !== 1'b0 || pix_ready !== 1'b1) begin
                errors++;
                $display("FAIL ignore_cycle %0d: rv=%b cfg_rdy=%b pix_rdy=%b want 0/0/1",
                         c, res_valid, cfg_ready, pix_ready);
            end
        end
        res_ready = 1'b0; cfg_valid = 1'b0;
        for (int i = 0; i < 9; i++) pv[i] = 8'd10;
        send_pixels(9, 0);
        check_window("ignore", 20'd450);
        accept_result();
    endtask

    task automatic test_max();
        reset_dut();
        for (int i = 0; i < 9; i++) begin wv[i] = 8'd255; pv[i] = 8'd255; end
        load_weights();
        send_pixels(9, 0);
        check_window("max", 20'd585225);
        accept_result();
    endtask

    task automatic test_reset_mid();
        send_pixels(5, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || pix_ready !== 1'b0 || acc_en !== 1'b0 || acc_load !== 1'b0 ||
            acc_data !== 20'd0 || res_valid !== 1'b0 || res_data !== 20'd0) begin
            errors++;
            $display("FAIL midreset_state: cfg_rdy=%b pix_rdy=%b en=%b load=%b data=%0d rv=%b rd=%0d",
                     cfg_ready, pix_ready, acc_en, acc_load, acc_data, res_valid, res_data);
        end
        pix_valid = 1'b1; pix_data = 8'd7;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (pix_ready !== 1'b0 || acc_en !== 1'b0) begin
                errors++;
                $display("FAIL midreset_pix_blocked %0d: pix_rdy=%b en=%b want 0/0", c, pix_ready, acc_en);
            end
        end
        pix_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin wv[i] = 8'd1; pv[i] = 8'd3; end
        load_weights();
        send_pixels(9, 0);
        check_window("midreset", 20'd27);
        accept_result();
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 9; i++) begin wv[i] = 8'd1; pv[i] = 8'd1; end
        load_weights();
        send_pixels(9, 0);
        check_window("b2b_first", 20'd9);
        accept_result();
        for (int i = 0; i < 9; i++) pv[i] = 8'd2;
        send_pixels(9, 0);
        check_window("b2b_second", 20'd18);
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_result_hold();
        test_ignore();
        test_max();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter TAPS, default 9, meaning taps per output pixel (3x3 kernel); range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cfg_valid  input  1  weight word offered.
REQ-005 SHALL have port cfg_weight  input  8  unsigned kernel weight.
REQ-006 SHALL have port cfg_ready  output  1  weight accepted when cfg_valid&cfg_ready.
REQ-007 SHALL have port pix_valid  input  1  pixel offered.
REQ-008 SHALL have port pix_data  input  8  unsigned window pixel, raster tap order.
REQ-009 SHALL have port pix_ready  output  1  pixel accepted when pix_valid&pix_ready.
REQ-010 SHALL have port acc_en  output  1  accumulator enable.
REQ-011 SHALL have port acc_load  output  1  accumulator load-new-value (first tap).
REQ-012 SHALL have port acc_data  output  20  product to accumulator.
REQ-013 SHALL have port acc_result  input  20  accumulator running sum.
REQ-014 SHALL have ports res_valid output 1, res_data output 20, res_ready input 1: result handshake.

Function
REQ-015 SHALL implement FSM LOAD, RUN, WAIT, RESULT; LOAD entered from reset.
REQ-016 In LOAD, cfg_ready=1; each cfg handshake SHALL store the weight at index k (0..TAPS-1), k increments; after index TAPS-1 go to RUN; pix_ready=0.
REQ-017 In RUN, pix_ready=1, cfg_ready=0; each pixel handshake at tap t SHALL, in the next cycle, drive acc_en=1, acc_load=(t==0), acc_data=zero-extended 16-bit pix_data*w[t].
REQ-018 Cycles without a pixel handshake SHALL drive acc_en=0, acc_load=0, acc_data=0 in the following cycle; tap index holds.
REQ-019 Tap index SHALL wrap TAPS-1 -> 0; handshake at t=TAPS-1 SHALL move FSM to WAIT with pix_ready=0 from the next cycle.
REQ-020 WAIT SHALL last 2 cycles (product issue, accumulator settle), then capture acc_result into res_data and enter RESULT with res_valid=1: res_valid rises exactly 3 cycles after the last-tap handshake cycle.
REQ-021 In RESULT, res_data/res_valid SHALL hold stable until res_ready=1; on handshake res_valid=0 next cycle and FSM returns to RUN with t=0.
REQ-022 res_ready asserted outside RESULT SHALL have no effect; cfg_valid outside LOAD SHALL be ignored.
REQ-023 Arithmetic SHALL be unsigned, no saturation; max sum 16*255*255 fits 20 bits.
REQ-024 acc_en SHALL never be 1 with acc_load=1 except at tap 0.

Reset
REQ-025 On rst=1 at a clock edge: FSM=LOAD, k=0, t=0, all weights=0, cfg_ready=1 next cycle, pix_ready=0, acc_en=0, acc_load=0, acc_data=0, res_valid=0, res_data=0.
REQ-026 Reset mid-window or in RESULT SHALL discard partial/pending results; weights reload required.

Structure
REQ-027 Shared package SHALL hold FSM state enum, widths PIX_W=8, W_W=8, ACC_W=20.
REQ-028 One sub-module SHALL exist: mac_feeder_wbank (weight register file, write port plus tap-indexed read).
REQ-029 Block SHALL connect port-for-port to the team accumulator (acc_en->en, acc_load->load_new_value, acc_data->data_in, acc_out->acc_result), rst polarity adapted at top.

Verification
REQ-030 Load weights 1..9, stream pixels all 10 -> res_data=450, res_valid 3 cycles after 9th pixel.
REQ-031 Weights all 255, pixels all 255 -> res_data=585225, no overflow.
REQ-032 pix_valid gaps of 2 cycles between taps -> acc_en low in gaps, result identical to gapless run.
REQ-033 res_ready held 0 for 5 cycles in RESULT -> res_data stable, pix_ready=0, then next window starts with acc_load=1 at tap 0.
REQ-034 rst pulsed after tap 4 -> all outputs at reset values, cfg_ready=1, pixels ignored until 9 new weights loaded.
REQ-035 Two back-to-back windows (pixels 1 then 2, weights all 1) -> results 9 then 18; second window's first acc_load=1 discards prior sum.
